// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM state encoding
// plus the default datapath width and reset PC.
package ifu_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: redirect input, memory request/response, instruction output.
// Handshakes: a request transfers on a cycle with req_valid && req_ready, an
// instruction pops on inst_valid && inst_ready; rsp_valid is a one-cycle strobe.
interface ifu_fetch_if #(parameter int XLEN = ifu_pkg::XLEN_DEF);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_misalign;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, inst_ready,
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, inst_ready,
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_misalign
  );

endinterface

// File: rtl/ifu_fifo.sv
// Registered instruction buffer: power-of-2 ring with push/pop/flush and an
// occupancy count. Flush has priority; pop on empty and push on full are ignored.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding memory read, responses buffered with PC.
// Optional IFU_FETCH_MISALIGN_CHK_EN turns a misaligned PC into a flagged entry.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_if.master   bus,
  output fetch_state_e  o_dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFU_FETCH_MISALIGN_CHK_EN
  localparam int EW = 2 * XLEN + 1;
`else
  localparam int EW = 2 * XLEN;
`endif

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop_eff;
  logic            w_flush;
  logic            w_mis_issue;
  logic            w_hold;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;
  logic            w_head_valid;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_cnt_after;

`ifdef IFU_FETCH_MISALIGN_CHK_EN
  logic r_halt;

  // A misaligned PC parks the unit in IDLE until software redirects it.
  assign w_mis_issue = (r_state == ST_REQ) && (r_pc[1:0] != 2'b00);
  assign w_hold      = r_halt;

  always_ff @(posedge clk) begin
    if (rst)                     r_halt <= 1'b0;
    else if (bus.redirect_valid) r_halt <= 1'b0;
    else if (w_mis_issue)        r_halt <= 1'b1;
  end
`else
  assign w_mis_issue = 1'b0;
  assign w_hold      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.redirect_valid || (!w_hold && (w_count < CW'(DEPTH))))
          w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.redirect_valid) w_state_nxt = w_req_fire ? ST_DROP : ST_REQ;
        else if (w_mis_issue)   w_state_nxt = ST_IDLE;
        else if (w_req_fire)    w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rsp_valid)
          w_state_nxt = (bus.redirect_valid || (w_cnt_after < CW'(DEPTH))) ? ST_REQ : ST_IDLE;
        else if (bus.redirect_valid)
          w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (bus.rsp_valid) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_valid = (r_state == ST_REQ) && !w_mis_issue;
    w_req_fire  = w_req_valid && bus.req_ready;
    w_flush     = bus.redirect_valid;
    w_push      = ((r_state == ST_WAIT) && bus.rsp_valid) || w_mis_issue;
    w_pop_eff   = bus.inst_ready && w_head_valid;
    w_cnt_after = w_count + CW'(1) - CW'(w_pop_eff);
`ifdef IFU_FETCH_MISALIGN_CHK_EN
    w_push_data = {w_mis_issue, r_pc, w_mis_issue ? {XLEN{1'b0}} : bus.rsp_data};
`else
    w_push_data = {r_pc, bus.rsp_data};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)                                        r_pc <= RESET_PC;
    else if (bus.redirect_valid)                    r_pc <= bus.redirect_pc;
    else if ((r_state == ST_WAIT) && bus.rsp_valid) r_pc <= r_pc + XLEN'(4);
  end

  ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop_eff),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign bus.req_valid  = w_req_valid;
  assign bus.req_addr   = r_pc;
  assign bus.inst_valid = w_head_valid;
  assign bus.inst       = w_head[XLEN-1:0];
  assign bus.inst_pc    = w_head[2*XLEN-1:XLEN];
`ifdef IFU_FETCH_MISALIGN_CHK_EN
  assign bus.inst_misalign = w_head_valid && w_head[2*XLEN];
`else
  assign bus.inst_misalign = 1'b0;
`endif
  assign o_dbg_state = r_state;

endmodule
